// File: rtl/nvc293_pkg.sv
// ============================================================================
// Module   : nvc293_pkg
// Brief    : Shared types and constants for the NVC293 delay-line sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package nvc293_pkg;

   typedef struct packed {
      logic       delay;
      logic [1:0] sel;
   } dly_cfg_t;

   localparam logic [1:0] SEL_MAX     = 2'd3;
   localparam dly_cfg_t   DLY_CFG_RST = '0;

endpackage : nvc293_pkg

`default_nettype wire

// File: rtl/nvc293_ctrl_chan.sv
// ============================================================================
// Module   : nvc293_ctrl_chan
// Brief    : One delay-line channel: staged setting, live setting, pending
//            flag and optional sel ramp (enabled by DLYCTL_RAMP_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nvc293_ctrl_chan
   import nvc293_pkg::*;
(
   input  logic     clk,
   input  logic     nRESET,
   input  logic     wr_en,
   input  dly_cfg_t wr_data,
   input  logic     commit,
   output dly_cfg_t stage,
   output dly_cfg_t live,
   output logic     pending
);

   dly_cfg_t   r_stage;
   dly_cfg_t   r_live;
   logic       r_pending;
   logic [1:0] w_next_sel;
   logic       w_do_commit;

   assign w_do_commit = commit & r_pending;

`ifdef DLYCTL_RAMP_EN
   // Step one tap per commit so the video path never sees a large jump.
   always_comb begin
      w_next_sel = r_live.sel;
      if ((r_live.sel != SEL_MAX) && (r_live.sel < r_stage.sel)) begin
         w_next_sel = r_live.sel + 2'd1;
      end else if (r_live.sel > r_stage.sel) begin
         w_next_sel = r_live.sel - 2'd1;
      end
   end
`else
   assign w_next_sel = r_stage.sel;
`endif

   // Commit reads the pre-edge stage, so a same-cycle write stays pending.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_stage   <= DLY_CFG_RST;
         r_live    <= DLY_CFG_RST;
         r_pending <= 1'b0;
      end else begin
         if (w_do_commit) begin
            r_live.delay <= r_stage.delay;
            r_live.sel   <= w_next_sel;
         end
         if (wr_en) begin
            r_stage   <= wr_data;
            r_pending <= 1'b1;
         end else if (w_do_commit && (w_next_sel == r_stage.sel)) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign stage   = r_stage;
   assign live    = r_live;
   assign pending = r_pending;

endmodule : nvc293_ctrl_chan

`default_nettype wire

// File: rtl/nvc293_ctrl.sv
// ============================================================================
// Module   : nvc293_ctrl
// Brief    : Line-synchronous configuration sequencer for NCH NVC293 delay
//            lines. Optional sel ramp selected by macro DLYCTL_RAMP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nvc293_ctrl
   import nvc293_pkg::*;
#(
   parameter int NCH = 4,
   parameter int AW  = 2
)(
   input  logic             clk,
   input  logic             nRESET,
   input  logic             cpu_we,
   input  logic [AW-1:0]    cpu_addr,
   input  logic [2:0]       cpu_din,
   output logic [2:0]       cpu_dout,
   input  logic             line_strobe,
   input  logic             commit_en,
   output logic [NCH-1:0]   pending,
   output logic [2*NCH-1:0] sel_out,
   output logic [NCH-1:0]   delay_out
);

   dly_cfg_t       w_stage [NCH];
   dly_cfg_t       w_live  [NCH];
   logic [NCH-1:0] w_wr_en;
   logic           w_commit;
   dly_cfg_t       w_rd;
   logic [2:0]     r_cpu_dout;

   assign w_commit = line_strobe & commit_en;

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_chan
         assign w_wr_en[i] = cpu_we && (cpu_addr == AW'(i));

         nvc293_ctrl_chan u_chan (
            .clk     (clk),
            .nRESET  (nRESET),
            .wr_en   (w_wr_en[i]),
            .wr_data (dly_cfg_t'(cpu_din)),
            .commit  (w_commit),
            .stage   (w_stage[i]),
            .live    (w_live[i]),
            .pending (pending[i])
         );

         assign sel_out[2*i +: 2] = w_live[i].sel;
         assign delay_out[i]      = w_live[i].delay;
      end
   endgenerate

   // Addresses with no channel fall through to zero.
   always_comb begin
      w_rd = DLY_CFG_RST;
      for (int i = 0; i < NCH; i++) begin
         if (cpu_addr == AW'(i)) begin
            w_rd = w_stage[i];
         end
      end
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_cpu_dout <= 3'b000;
      end else begin
         r_cpu_dout <= w_rd;
      end
   end

   assign cpu_dout = r_cpu_dout;

endmodule : nvc293_ctrl

`default_nettype wire

// File: tb/tb_nvc293_ctrl.sv
// ============================================================================
// Module   : tb_nvc293_ctrl
// Brief    : Self-checking bench: a 4-channel and a 3-channel instance driven
//            in parallel and compared against a behavioural channel model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nvc293_ctrl;

`ifdef DLYCTL_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       nRESET = 1'b1;
   logic       cpu_we = 1'b0;
   logic [1:0] cpu_addr = 2'd0;
   logic [2:0] cpu_din = 3'd0;
   logic       line_strobe = 1'b0;
   logic       commit_en = 1'b0;

   logic [2:0] dout4, dout3;
   logic [3:0] pend4, dly4;
   logic [7:0] sel4;
   logic [2:0] pend3, dly3;
   logic [5:0] sel3;

   int errors = 0;
   int checks = 0;

   // Reference state: staged word, live sel/delay and pending per channel.
   logic [2:0] m_stage [4];
   logic [1:0] m_sel   [4];
   logic       m_dly   [4];
   logic       m_pend  [4];
   logic [2:0] exp_dout4, exp_dout3;

   always #5 clk = ~clk;

   nvc293_ctrl #(.NCH(4), .AW(2)) u_dut4 (
      .clk(clk), .nRESET(nRESET), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(dout4), .line_strobe(line_strobe),
      .commit_en(commit_en), .pending(pend4), .sel_out(sel4), .delay_out(dly4)
   );

   nvc293_ctrl #(.NCH(3), .AW(2)) u_dut3 (
      .clk(clk), .nRESET(nRESET), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(dout3), .line_strobe(line_strobe),
      .commit_en(commit_en), .pending(pend3), .sel_out(sel3), .delay_out(dly3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_stage[i] = 3'd0; m_sel[i] = 2'd0; m_dly[i] = 1'b0; m_pend[i] = 1'b0;
      end
      exp_dout4 = 3'd0;
      exp_dout3 = 3'd0;
   endtask

   // Predict the effect of the coming clock edge from the current inputs.
   task automatic model_step();
      logic [2:0] old_stage [4];
      logic [1:0] tgt;
      for (int i = 0; i < 4; i++) old_stage[i] = m_stage[i];
      exp_dout4 = old_stage[cpu_addr];
      exp_dout3 = (cpu_addr == 2'd3) ? 3'd0 : old_stage[cpu_addr];
      if (line_strobe && commit_en) begin
         for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) begin
               tgt      = old_stage[i][1:0];
               m_dly[i] = old_stage[i][2];
               if (!RAMP)               m_sel[i] = tgt;
               else if (tgt > m_sel[i]) m_sel[i] = m_sel[i] + 2'd1;
               else if (tgt < m_sel[i]) m_sel[i] = m_sel[i] - 2'd1;
               if (m_sel[i] == tgt) m_pend[i] = 1'b0;
            end
         end
      end
      if (cpu_we) begin
         m_stage[cpu_addr] = cpu_din;
         m_pend[cpu_addr]  = 1'b1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] es4; logic [3:0] ep4, ed4;
      for (int i = 0; i < 4; i++) begin
         es4[2*i +: 2] = m_sel[i];
         ep4[i]        = m_pend[i];
         ed4[i]        = m_dly[i];
      end
      chk({tag, ".sel4"},  32'(sel4),  32'(es4));
      chk({tag, ".pend4"}, 32'(pend4), 32'(ep4));
      chk({tag, ".dly4"},  32'(dly4),  32'(ed4));
      chk({tag, ".dout4"}, 32'(dout4), 32'(exp_dout4));
      chk({tag, ".sel3"},  32'(sel3),  32'(es4[5:0]));
      chk({tag, ".pend3"}, 32'(pend3), 32'(ep4[2:0]));
      chk({tag, ".dly3"},  32'(dly3),  32'(ed4[2:0]));
      chk({tag, ".dout3"}, 32'(dout3), 32'(exp_dout3));
   endtask

   task automatic step(input logic we, input logic [1:0] addr, input logic [2:0] din,
                       input logic stb, input logic ce, input string tag);
      cpu_we = we; cpu_addr = addr; cpu_din = din; line_strobe = stb; commit_en = ce;
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      cpu_we = 1'b0; cpu_addr = 2'd0; cpu_din = 3'd0; line_strobe = 1'b0; commit_en = 1'b0;
      nRESET = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      nRESET = 1'b1;
      step(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, {tag, "_rel"});
   endtask

   initial begin
      model_reset();
      #2;
      do_reset("reset");

      // Commit of a single channel.
      step(1'b1, 2'd1, 3'b110, 1'b0, 1'b0, "t1_wr");
      step(1'b0, 2'd1, 3'd0,   1'b1, 1'b1, "t1_stb");
      if (RAMP) step(1'b0, 2'd1, 3'd0, 1'b1, 1'b1, "t1_stb2");
      chk("t1_sel1",  32'(sel4[3:2]), 32'(2'b10));
      chk("t1_dly1",  32'(dly4[1]),   32'(1'b1));
      chk("t1_pend1", 32'(pend4[1]),  32'(1'b0));

      // Disabled strobe holds pending.
      step(1'b1, 2'd0, 3'b011, 1'b0, 1'b0, "t2_wr");
      step(1'b0, 2'd0, 3'd0,   1'b1, 1'b0, "t2_hold");
      chk("t2_sel0_hold", 32'(sel4[1:0]), 32'(2'b00));
      chk("t2_pend0",     32'(pend4[0]),  32'(1'b1));
      step(1'b0, 2'd0, 3'd0,   1'b1, 1'b1, "t2_stb");
      if (RAMP) begin
         step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1, "t2_stb2");
         step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1, "t2_stb3");
      end
      chk("t2_sel0", 32'(sel4[1:0]), 32'(2'b11));

      // Same-cycle write and strobe on one channel.
      step(1'b1, 2'd2, 3'b100, 1'b0, 1'b0, "t3_pre");
      step(1'b0, 2'd2, 3'd0,   1'b1, 1'b1, "t3_pre_stb");
      step(1'b1, 2'd2, 3'b001, 1'b1, 1'b1, "t3_wrstb");
      chk("t3_sel2",  32'(sel4[5:4]), 32'(2'b00));
      chk("t3_dly2",  32'(dly4[2]),   32'(1'b1));
      chk("t3_pend2", 32'(pend4[2]),  32'(1'b1));
      step(1'b0, 2'd2, 3'd0, 1'b0, 1'b0, "t3_rd");
      chk("t3_dout2", 32'(dout4), 32'(3'b001));

      // Last write wins; addr 3 is out of range for the 3-channel instance.
      step(1'b1, 2'd3, 3'b010, 1'b0, 1'b0, "t4_wr1");
      step(1'b1, 2'd3, 3'b101, 1'b0, 1'b0, "t4_wr2");
      step(1'b0, 2'd3, 3'd0,   1'b1, 1'b1, "t4_stb");
      chk("t4_sel3", 32'(sel4[7:6]), 32'(2'b01));
      chk("t4_dly3", 32'(dly4[3]),   32'(1'b1));
      step(1'b0, 2'd3, 3'd0,   1'b0, 1'b0, "t6_rd");
      chk("t6_dout3_n3", 32'(dout3), 32'(3'b000));
      chk("t6_dout3_n4", 32'(dout4), 32'(3'b101));

`ifdef DLYCTL_RAMP_EN
      do_reset("t5_rst");
      step(1'b1, 2'd0, 3'b011, 1'b0, 1'b0, "t5_wr");
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1, "t5_s1");
      chk("t5_sel_s1", 32'(sel4[1:0]), 32'(2'd1));
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1, "t5_s2");
      chk("t5_sel_s2", 32'(sel4[1:0]), 32'(2'd2));
      chk("t5_pend_s2", 32'(pend4[0]), 32'(1'b1));
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1, "t5_s3");
      chk("t5_sel_s3", 32'(sel4[1:0]), 32'(2'd3));
      chk("t5_pend_s3", 32'(pend4[0]), 32'(1'b0));
      do_reset("t5_rst2");
      step(1'b1, 2'd0, 3'b011, 1'b0, 1'b0, "t5b_wr");
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1, "t5b_s1");
      step(1'b0, 2'd0, 3'd0, 1'b1, 1'b1, "t5b_s2");
      do_reset("t5_abort");
      chk("t5_abort_sel", 32'(sel4), 32'(8'd0));
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7), "rand");
         if (n == 200) do_reset("rand_rst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule : tb_nvc293_ctrl

`default_nettype wire
